output_demux: RTL and testbench
===============================

OUTPUT_DEMUX -- requirements
Module: output_demux

Interface
REQ-001 SHALL have parameter C_M_AXIS_DATA_WIDTH, default 256, master tdata width.
REQ-002 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, slave tdata width; must equal C_M_AXIS_DATA_WIDTH.
REQ-003 SHALL have parameter C_M_AXIS_TUSER_WIDTH, default 128, master tuser width.
REQ-004 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, slave tuser width; must equal C_M_AXIS_TUSER_WIDTH.
REQ-005 SHALL have parameter NUM_QUEUES, default 5, output port count; port set fixed at 0..4.
REQ-006 SHALL have parameter DST_POS, default 24, LSB of the one-hot destination field in tuser.
REQ-007 axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-008 axi_resetn  in  1  reset, synchronous, active-low.
REQ-009 s_axis_tdata / tstrb / tuser  in  C_S_AXIS_DATA_WIDTH / C_S_AXIS_DATA_WIDTH/8 / C_S_AXIS_TUSER_WIDTH  input word.
REQ-010 s_axis_tvalid  in  1; s_axis_tready  out  1; s_axis_tlast  in  1  input handshake, end of packet.
REQ-011 m_axis_tdata_k / tstrb_k / tuser_k  out  same widths  output word, k=0..4.
REQ-012 m_axis_tvalid_k  out  1; m_axis_tready_k  in  1; m_axis_tlast_k  out  1  per-port handshake, k=0..4.
REQ-013 pkt_fwd  out  1  one-cycle pulse per forwarded packet, registered.
REQ-014 pkt_drop  out  1  one-cycle pulse per dropped packet, registered.

Function
REQ-015 SHALL take destination only from the first word of a packet: dst = s_axis_tuser[DST_POS+NUM_QUEUES-1:DST_POS]; remaining tuser bits ignored for routing.
REQ-016 SHALL select lowest-index set bit of dst when several set (no multicast); dst==0 SHALL drop the packet.
REQ-017 SHALL hold one output register (data, strb, user, last, valid, port index); tdata/tstrb/tuser/tlast SHALL drive all five ports from it.
REQ-018 m_axis_tvalid_k SHALL be out_valid AND (out_port==k); never combinationally dependent on any tready.
REQ-019 Forwarded word SHALL appear on the selected port exactly 1 cycle after its input handshake.
REQ-020 Forward path: s_axis_tready = ~out_valid OR m_axis_tready_[out_port]; full throughput (1 word/cycle) when selected port ready.
REQ-021 Unselected ports' tready SHALL have no effect on any output.
REQ-022 States: IDLE (expect first word), FWD (mid-packet, port latched), DROP (discard to tlast).
REQ-023 IDLE, handshake, dst!=0: load register, latch port, pulse pkt_fwd next cycle; tlast=0 -> FWD, tlast=1 -> stay IDLE.
REQ-024 IDLE, dst==0: s_axis_tready=1 regardless of output register; word discarded, pkt_drop pulsed next cycle; tlast=0 -> DROP, tlast=1 -> stay IDLE.
REQ-025 FWD: every word to latched port, tuser not re-decoded; handshake with tlast=1 -> IDLE.
REQ-026 DROP: s_axis_tready=1, words discarded, output register untouched; handshake with tlast=1 -> IDLE.
REQ-027 Output register drain and new load in the same cycle SHALL be legal (back-to-back, including packets to different ports).
REQ-028 out_valid SHALL hold and data SHALL stay stable while m_axis_tready_[out_port]=0.
REQ-029 Input stalls (s_axis_tvalid=0) mid-packet SHALL not change state or latched port.

Reset
REQ-030 axi_resetn=0 at a clock edge SHALL set state=IDLE, out_valid=0, out_port=0, pkt_fwd=0, pkt_drop=0; all m_axis_tvalid_k=0 next cycle.
REQ-031 Reset mid-packet SHALL discard the partial packet and held word; first word after reset SHALL be decoded as a new packet.
REQ-032 s_axis_tready SHALL be 1 from the first cycle after reset release (register empty).

Verification
REQ-033 3-word packet, tuser[28:24]=5'b00100, all ready -> words on port 2, 1-cycle latency, tlast on word 3, one pkt_fwd pulse, other tvalids 0.
REQ-034 dst=5'b01010 -> lowest bit wins; packet on port 1 only.
REQ-035 dst=0, 4-word packet, all m_axis_tready=0 -> s_axis_tready=1 all 4 cycles, no tvalid, one pkt_drop pulse.
REQ-036 Back-to-back 1-word packets to ports 0,4,3 continuously, ready high -> 3 words in 3 consecutive cycles on correct ports, 3 pkt_fwd pulses.
REQ-037 Port 3 tready toggling 0/1 mid-packet, port 0 tready=1 -> no loss, no duplication, data stable while stalled, s_axis_tready follows port 3 only.
REQ-038 axi_resetn=0 for 1 cycle after word 2 of a 5-word packet -> all tvalid 0; next packet with dst=5'b00001 delivered intact on port 0.

Source files
------------

// File: rtl/output_demux_if.sv
// ---------------------------------------------------------------------------
// output_demux_if
// Stream bundle around the output demultiplexer: one slave-side input
// stream (s_axis_*) and five master-side output streams (m_axis_*_0..4).
//
// Modports:
//   slave  : the demux's view; it receives s_axis_* and drives m_axis_*,
//            taking m_axis_tready_k back in.
//   master : the surrounding logic's view; it drives the input stream and
//            the output readies, and observes everything else.
// ---------------------------------------------------------------------------
interface output_demux_if #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 128
);

  logic [DATA_WIDTH-1:0]   s_axis_tdata;
  logic [DATA_WIDTH/8-1:0] s_axis_tstrb;
  logic [TUSER_WIDTH-1:0]  s_axis_tuser;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic                    s_axis_tlast;

  logic [DATA_WIDTH-1:0]   m_axis_tdata_0, m_axis_tdata_1, m_axis_tdata_2, m_axis_tdata_3, m_axis_tdata_4;
  logic [DATA_WIDTH/8-1:0] m_axis_tstrb_0, m_axis_tstrb_1, m_axis_tstrb_2, m_axis_tstrb_3, m_axis_tstrb_4;
  logic [TUSER_WIDTH-1:0]  m_axis_tuser_0, m_axis_tuser_1, m_axis_tuser_2, m_axis_tuser_3, m_axis_tuser_4;
  logic m_axis_tvalid_0, m_axis_tvalid_1, m_axis_tvalid_2, m_axis_tvalid_3, m_axis_tvalid_4;
  logic m_axis_tready_0, m_axis_tready_1, m_axis_tready_2, m_axis_tready_3, m_axis_tready_4;
  logic m_axis_tlast_0, m_axis_tlast_1, m_axis_tlast_2, m_axis_tlast_3, m_axis_tlast_4;

  modport slave (
    input  s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata_0, m_axis_tdata_1, m_axis_tdata_2, m_axis_tdata_3, m_axis_tdata_4,
    output m_axis_tstrb_0, m_axis_tstrb_1, m_axis_tstrb_2, m_axis_tstrb_3, m_axis_tstrb_4,
    output m_axis_tuser_0, m_axis_tuser_1, m_axis_tuser_2, m_axis_tuser_3, m_axis_tuser_4,
    output m_axis_tvalid_0, m_axis_tvalid_1, m_axis_tvalid_2, m_axis_tvalid_3, m_axis_tvalid_4,
    output m_axis_tlast_0, m_axis_tlast_1, m_axis_tlast_2, m_axis_tlast_3, m_axis_tlast_4,
    input  m_axis_tready_0, m_axis_tready_1, m_axis_tready_2, m_axis_tready_3, m_axis_tready_4
  );

  modport master (
    output s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata_0, m_axis_tdata_1, m_axis_tdata_2, m_axis_tdata_3, m_axis_tdata_4,
    input  m_axis_tstrb_0, m_axis_tstrb_1, m_axis_tstrb_2, m_axis_tstrb_3, m_axis_tstrb_4,
    input  m_axis_tuser_0, m_axis_tuser_1, m_axis_tuser_2, m_axis_tuser_3, m_axis_tuser_4,
    input  m_axis_tvalid_0, m_axis_tvalid_1, m_axis_tvalid_2, m_axis_tvalid_3, m_axis_tvalid_4,
    input  m_axis_tlast_0, m_axis_tlast_1, m_axis_tlast_2, m_axis_tlast_3, m_axis_tlast_4,
    output m_axis_tready_0, m_axis_tready_1, m_axis_tready_2, m_axis_tready_3, m_axis_tready_4
  );

endinterface

// File: rtl/output_demux.sv
// ---------------------------------------------------------------------------
// output_demux
// Routes whole packets from one input stream to one of five output streams.
// The destination is a one-hot field in tuser of the first word; the lowest
// set bit wins, and an all-zero field drops the packet. A single output
// register feeds all five ports; only the selected port sees tvalid.
//
// Ports:
//   axi_aclk    : clock, rising edge
//   axi_resetn  : synchronous, active-low reset
//   bus         : output_demux_if.slave (input stream + five output streams)
//   pkt_fwd     : one-cycle pulse per forwarded packet (registered)
//   pkt_drop    : one-cycle pulse per dropped packet (registered)
// ---------------------------------------------------------------------------
module output_demux #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES           = 5,
  parameter int DST_POS              = 24
) (
  input  logic          axi_aclk,
  input  logic          axi_resetn,
  output_demux_if.slave bus,
  output logic          pkt_fwd,
  output logic          pkt_drop
);

  // Master and slave sides share one register, so their widths must agree.
  if (C_S_AXIS_DATA_WIDTH != C_M_AXIS_DATA_WIDTH) begin : g_data_width_err
    $error("output_demux: slave and master tdata widths differ");
  end
  if (C_S_AXIS_TUSER_WIDTH != C_M_AXIS_TUSER_WIDTH) begin : g_user_width_err
    $error("output_demux: slave and master tuser widths differ");
  end

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t                              state_q, state_d;
  logic                                outValid_q, outValid_d;
  logic [2:0]                          outPort_q, outPort_d;
  logic [C_M_AXIS_DATA_WIDTH-1:0]      data_q;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]    strb_q;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]     user_q;
  logic                                last_q;
  logic                                pktFwd_q, pktFwd_d;
  logic                                pktDrop_q, pktDrop_d;

  logic [NUM_QUEUES-1:0] dst;
  logic                  dstZero;
  logic [2:0]            firstPort;
  logic                  selReady;
  logic                  regFree;
  logic                  sReady;
  logic                  load;

  assign dst     = bus.s_axis_tuser[DST_POS +: NUM_QUEUES];
  assign dstZero = (dst == '0);

  // Lowest-index set bit wins; scanning downward leaves the lowest as winner.
  always_comb begin
    firstPort = 3'd0;
    for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
      if (dst[k]) firstPort = 3'(k);
    end
  end

  // Only the ready of the port currently holding the word matters.
  always_comb begin
    selReady = 1'b0;
    case (outPort_q)
      3'd0:    selReady = bus.m_axis_tready_0;
      3'd1:    selReady = bus.m_axis_tready_1;
      3'd2:    selReady = bus.m_axis_tready_2;
      3'd3:    selReady = bus.m_axis_tready_3;
      3'd4:    selReady = bus.m_axis_tready_4;
      default: selReady = 1'b0;
    endcase
  end

  // The register can take a word if it is empty or is draining this cycle.
  assign regFree = ~outValid_q | selReady;

  // Packet FSM: dropped words never touch the output register, so their
  // ready is unconditional even while the register is stalled.
  always_comb begin
    state_d   = state_q;
    outPort_d = outPort_q;
    sReady    = regFree;
    load      = 1'b0;
    pktFwd_d  = 1'b0;
    pktDrop_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (dstZero) begin
          sReady = 1'b1;
          if (bus.s_axis_tvalid) begin
            pktDrop_d = 1'b1;
            if (!bus.s_axis_tlast) state_d = DROP;
          end
        end else if (bus.s_axis_tvalid && regFree) begin
          load      = 1'b1;
          outPort_d = firstPort;
          pktFwd_d  = 1'b1;
          if (!bus.s_axis_tlast) state_d = FWD;
        end
      end
      FWD: begin
        if (bus.s_axis_tvalid && regFree) begin
          load = 1'b1;
          if (bus.s_axis_tlast) state_d = IDLE;
        end
      end
      DROP: begin
        sReady = 1'b1;
        if (bus.s_axis_tvalid && bus.s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    outValid_d = load | (outValid_q & ~selReady);
  end

  // Control state with synchronous reset.
  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state_q    <= IDLE;
      outValid_q <= 1'b0;
      outPort_q  <= 3'd0;
      pktFwd_q   <= 1'b0;
      pktDrop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      outValid_q <= outValid_d;
      outPort_q  <= outPort_d;
      pktFwd_q   <= pktFwd_d;
      pktDrop_q  <= pktDrop_d;
    end
  end

  // Payload is qualified by outValid_q, so it needs no reset.
  always_ff @(posedge axi_aclk) begin
    if (load) begin
      data_q <= bus.s_axis_tdata;
      strb_q <= bus.s_axis_tstrb;
      user_q <= bus.s_axis_tuser;
      last_q <= bus.s_axis_tlast;
    end
  end

  assign bus.s_axis_tready = sReady;
  assign pkt_fwd           = pktFwd_q;
  assign pkt_drop          = pktDrop_q;

  assign bus.m_axis_tdata_0 = data_q;
  assign bus.m_axis_tdata_1 = data_q;
  assign bus.m_axis_tdata_2 = data_q;
  assign bus.m_axis_tdata_3 = data_q;
  assign bus.m_axis_tdata_4 = data_q;
  assign bus.m_axis_tstrb_0 = strb_q;
  assign bus.m_axis_tstrb_1 = strb_q;
  assign bus.m_axis_tstrb_2 = strb_q;
  assign bus.m_axis_tstrb_3 = strb_q;
  assign bus.m_axis_tstrb_4 = strb_q;
  assign bus.m_axis_tuser_0 = user_q;
  assign bus.m_axis_tuser_1 = user_q;
  assign bus.m_axis_tuser_2 = user_q;
  assign bus.m_axis_tuser_3 = user_q;
  assign bus.m_axis_tuser_4 = user_q;
  assign bus.m_axis_tlast_0 = last_q;
  assign bus.m_axis_tlast_1 = last_q;
  assign bus.m_axis_tlast_2 = last_q;
  assign bus.m_axis_tlast_3 = last_q;
  assign bus.m_axis_tlast_4 = last_q;

  assign bus.m_axis_tvalid_0 = outValid_q && (outPort_q == 3'd0);
  assign bus.m_axis_tvalid_1 = outValid_q && (outPort_q == 3'd1);
  assign bus.m_axis_tvalid_2 = outValid_q && (outPort_q == 3'd2);
  assign bus.m_axis_tvalid_3 = outValid_q && (outPort_q == 3'd3);
  assign bus.m_axis_tvalid_4 = outValid_q && (outPort_q == 3'd4);

endmodule

// File: tb/tb_output_demux.sv
// ---------------------------------------------------------------------------
// tb_output_demux
// Self-checking bench for output_demux. Every accepted word that should be
// forwarded is pushed to a scoreboard with its intended port; a monitor on
// the falling edge compares whatever the DUT presents against the head.
// ---------------------------------------------------------------------------
module tb_output_demux;

  logic clk;
  logic resetn;
  logic pktFwd, pktDrop;

  logic [4:0] baseReady;
  logic [4:0] togReady;
  bit         toggleOn;
  logic [4:0] readyVec;
  logic [4:0] tvalidVec;

  int  nAsserts = 0;
  int  nFail    = 0;
  int  cycle    = 0;
  int  fwdExp   = 0;
  int  dropExp  = 0;
  int  fwdSeen  = 0;
  int  dropSeen = 0;
  bit  monEn    = 0;
  bit  chk3     = 0;

  typedef struct {
    int           port;
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
    int           hsCycle;
    bit           seen;
  } exp_t;
  exp_t expQ[$];

  typedef struct {
    logic [4:0] dst;
    int         nWords;
    int         expPort;
    logic [4:0] ready;
    bit         gap;
  } vec_t;
  vec_t vecs[10];

  output_demux_if #(.DATA_WIDTH(256), .TUSER_WIDTH(128)) bus ();

  output_demux #(
    .C_M_AXIS_DATA_WIDTH(256), .C_S_AXIS_DATA_WIDTH(256),
    .C_M_AXIS_TUSER_WIDTH(128), .C_S_AXIS_TUSER_WIDTH(128),
    .NUM_QUEUES(5), .DST_POS(24)
  ) dut (
    .axi_aclk(clk),
    .axi_resetn(resetn),
    .bus(bus),
    .pkt_fwd(pktFwd),
    .pkt_drop(pktDrop)
  );

  assign readyVec = toggleOn ? togReady : baseReady;
  assign bus.m_axis_tready_0 = readyVec[0];
  assign bus.m_axis_tready_1 = readyVec[1];
  assign bus.m_axis_tready_2 = readyVec[2];
  assign bus.m_axis_tready_3 = readyVec[3];
  assign bus.m_axis_tready_4 = readyVec[4];
  assign tvalidVec = {bus.m_axis_tvalid_4, bus.m_axis_tvalid_3, bus.m_axis_tvalid_2,
                      bus.m_axis_tvalid_1, bus.m_axis_tvalid_0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Port 3 ready toggles every cycle; other unselected readies are random.
  initial begin
    togReady = 5'b00001;
    forever begin
      @(posedge clk);
      #1;
      togReady[3] = ~togReady[3];
      togReady[1] = 1'($urandom);
      togReady[2] = 1'($urandom);
      togReady[4] = 1'($urandom);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    nAsserts++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic getPort(input int p, output logic [255:0] d, output logic [31:0] s,
                         output logic [127:0] u, output logic l);
    case (p)
      0: begin d = bus.m_axis_tdata_0; s = bus.m_axis_tstrb_0; u = bus.m_axis_tuser_0; l = bus.m_axis_tlast_0; end
      1: begin d = bus.m_axis_tdata_1; s = bus.m_axis_tstrb_1; u = bus.m_axis_tuser_1; l = bus.m_axis_tlast_1; end
      2: begin d = bus.m_axis_tdata_2; s = bus.m_axis_tstrb_2; u = bus.m_axis_tuser_2; l = bus.m_axis_tlast_2; end
      3: begin d = bus.m_axis_tdata_3; s = bus.m_axis_tstrb_3; u = bus.m_axis_tuser_3; l = bus.m_axis_tlast_3; end
      default: begin d = bus.m_axis_tdata_4; s = bus.m_axis_tstrb_4; u = bus.m_axis_tuser_4; l = bus.m_axis_tlast_4; end
    endcase
  endtask

  // Scoreboard monitor: compares every presented word with the queue head,
  // including while stalled, so held data must stay stable.
  initial begin
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
    int           p;
    forever begin
      @(negedge clk);
      if (monEn) begin
        if (pktFwd === 1'b1) fwdSeen++;
        if (pktDrop === 1'b1) dropSeen++;
        if (chk3 && bus.s_axis_tvalid)
          checkOutput("tready_follows_port3", bus.s_axis_tready, !bus.m_axis_tvalid_3 || readyVec[3]);
        if (tvalidVec !== 5'b0) begin
          if ($countones(tvalidVec) != 1) begin
            checkOutput("tvalid_onehot", tvalidVec, 0);
          end else if (expQ.size() == 0) begin
            checkOutput("spurious_word", tvalidVec, 0);
          end else begin
            p = 0;
            for (int k = 0; k < 5; k++) if (tvalidVec[k]) p = k;
            getPort(p, d, s, u, l);
            checkOutput("out_port", p, expQ[0].port);
            checkOutput("out_data", d, expQ[0].data);
            checkOutput("out_strb", s, expQ[0].strb);
            checkOutput("out_user", u, expQ[0].user);
            checkOutput("out_last", l, expQ[0].last);
            if (!expQ[0].seen) checkOutput("latency", cycle - expQ[0].hsCycle, 1);
            expQ[0].seen = 1;
            if (readyVec[p]) void'(expQ.pop_front());
          end
        end
      end
    end
  end

  // Drive one word and hold it until accepted; forwarded words go to the scoreboard.
  task automatic applyStimulus(input logic [255:0] data, input logic [31:0] strb,
                               input logic [127:0] user, input logic last,
                               input int expPort, output int waits, output bit ok);
    exp_t e;
    bus.s_axis_tdata  = data;
    bus.s_axis_tstrb  = strb;
    bus.s_axis_tuser  = user;
    bus.s_axis_tlast  = last;
    bus.s_axis_tvalid = 1'b1;
    waits = 0;
    ok    = 1;
    forever begin
      @(negedge clk);
      if (bus.s_axis_tready === 1'b1) break;
      waits++;
      if (waits > 200) begin
        nAsserts++;
        nFail++;
        $display("[TB] FAIL handshake_timeout: no s_axis_tready after %0d cycles, expected acceptance", waits);
        ok = 0;
        break;
      end
    end
    if (ok && expPort >= 0) begin
      e.port = expPort; e.data = data; e.strb = strb; e.user = user;
      e.last = last; e.hsCycle = cycle; e.seen = 0;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Send a whole packet; tvalid is left high so callers can go back-to-back.
  task automatic sendPacket(input logic [4:0] dst, input int nWords, input int expPort,
                            input bit gap, output int totalWaits);
    logic [127:0] user;
    logic [255:0] r;
    int           w;
    bit           ok;
    totalWaits = 0;
    for (int i = 0; i < nWords; i++) begin
      r = rnd256();
      user = r[127:0];
      if (i == 0) user[24 +: 5] = dst;
      applyStimulus(rnd256(), $urandom, user, (i == nWords - 1), expPort, w, ok);
      totalWaits += w;
      if (expPort < 0) checkOutput("drop_ready", w, 0);
      if (i == 0 && ok) begin
        if (expPort >= 0) fwdExp++;
        else dropExp++;
      end
      if (gap && i == 0 && nWords > 1) begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tuser  = 128'h0 | (128'h1 << 28);
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, "_drain"}, expQ.size(), 0);
    checkOutput({tag, "_fwd_pulses"}, fwdSeen, fwdExp);
    checkOutput({tag, "_drop_pulses"}, dropSeen, dropExp);
  endtask

  initial begin
    int  w0, w1, w2;
    bit  ok;
    logic [127:0] user;

    vecs[0] = '{5'b00100, 3,  2, 5'b11111, 1'b0};
    vecs[1] = '{5'b01010, 2,  1, 5'b11111, 1'b0};
    vecs[2] = '{5'b00001, 1,  0, 5'b00001, 1'b0};
    vecs[3] = '{5'b10000, 2,  4, 5'b10000, 1'b1};
    vecs[4] = '{5'b11000, 3,  3, 5'b01000, 1'b1};
    vecs[5] = '{5'b00011, 1,  0, 5'b00001, 1'b0};
    vecs[6] = '{5'b00000, 2, -1, 5'b00000, 1'b0};
    vecs[7] = '{5'b10110, 4,  1, 5'b00010, 1'b1};
    vecs[8] = '{5'b00000, 1, -1, 5'b11111, 1'b0};
    vecs[9] = '{5'b00100, 5,  2, 5'b00100, 1'b1};

    resetn            = 1'b0;
    baseReady         = 5'b11111;
    toggleOn          = 0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tstrb  = '0;
    bus.s_axis_tuser  = '0;
    bus.s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    monEn  = 1;
    @(negedge clk);
    checkOutput("rst_tvalid", tvalidVec, 0);
    checkOutput("rst_pkt_fwd", pktFwd, 0);
    checkOutput("rst_pkt_drop", pktDrop, 0);
    checkOutput("rst_s_tready", bus.s_axis_tready, 1);
    @(posedge clk);
    #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      baseReady = vecs[i].ready;
      sendPacket(vecs[i].dst, vecs[i].nWords, vecs[i].expPort, vecs[i].gap, w0);
      bus.s_axis_tvalid = 1'b0;
      @(posedge clk);
      #1;
    end
    baseReady = 5'b11111;
    waitDrain("table");

    $display("[TB] back-to-back single-word packets to ports 0,4,3");
    sendPacket(5'b00001, 1, 0, 0, w0);
    sendPacket(5'b10000, 1, 4, 0, w1);
    sendPacket(5'b01000, 1, 3, 0, w2);
    bus.s_axis_tvalid = 1'b0;
    checkOutput("b2b_stall_cycles", w0 + w1 + w2, 0);
    waitDrain("b2b");

    $display("[TB] drop while output register is stalled");
    baseReady = 5'b00000;
    sendPacket(5'b00010, 1, 1, 0, w0);
    sendPacket(5'b00000, 4, -1, 0, w1);
    bus.s_axis_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    baseReady = 5'b11111;
    waitDrain("drop");

    $display("[TB] port 3 ready toggling mid-packet");
    toggleOn = 1;
    chk3     = 1;
    sendPacket(5'b01000, 8, 3, 1, w0);
    bus.s_axis_tvalid = 1'b0;
    chk3 = 0;
    @(posedge clk);
    #1;
    toggleOn = 0;
    waitDrain("toggle");

    $display("[TB] reset in the middle of a packet");
    user = 128'h0;
    user[24 +: 5] = 5'b00100;
    applyStimulus(rnd256(), 32'hffff_ffff, user, 1'b0, 2, w0, ok);
    if (ok) fwdExp++;
    applyStimulus(rnd256(), 32'h0f0f_0f0f, ~user, 1'b0, 2, w1, ok);
    bus.s_axis_tvalid = 1'b0;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    expQ.delete();
    @(negedge clk);
    checkOutput("midrst_tvalid", tvalidVec, 0);
    checkOutput("midrst_s_tready", bus.s_axis_tready, 1);
    @(posedge clk);
    #1;
    sendPacket(5'b00001, 3, 0, 0, w0);
    bus.s_axis_tvalid = 1'b0;
    waitDrain("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
